// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-Avalon bridge master.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam int unsigned CMD_BE_LSB    = 0;

    // Command + address + dummy bytes + data.
    function automatic int unsigned frame_bits(input int unsigned wait_bytes);
        return 72 + 8 * wait_bytes;
    endfunction

endpackage

// File: rtl/spi_bridge_tick.sv
// Half-period timer: rise ends a low half-period, fall ends a high one.
module spi_bridge_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic clear,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          half_done;

    assign half_done = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise      = half_done && !phase_q;
    assign fall      = half_done && phase_q;

    always_ff @(posedge clk) begin
        if (!nreset || !en || clear) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (half_done) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_bridge_master.sv
// SPI mode-0 master issuing one fixed-length register frame per accepted request.
// One shift register carries the outgoing frame from the MSB and collects miso at the LSB.
module spi_bridge_master
    import spi_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned WAIT_BYTES = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_clk,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned NBITS = frame_bits(WAIT_BYTES);
    localparam int unsigned BW    = $clog2(NBITS);
    localparam int unsigned GW    = $clog2(CLK_DIV + 1);

    state_e             state_q, state_d;
    logic [NBITS-1:0]   sr_q, sr_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               miso_q, miso_d;
    logic               csn_q, csn_d;
    logic               sclk_q, sclk_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         cmd;
    logic               tick_en, tick_clear, rise, fall;

    assign tick_en    = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    // The setup half-period must not leave the phase bit set for the first shift bit.
    assign tick_clear = (state_q == StSetup) && rise;

    spi_bridge_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .nreset(nreset),
        .en    (tick_en),
        .clear (tick_clear),
        .rise  (rise),
        .fall  (fall)
    );

    assign cmd = 8'((32'(req_write) << CMD_WRITE_BIT) | (32'(req_byte_enable) << CMD_BE_LSB));

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        miso_d      = miso_q;
        csn_d       = csn_q;
        sclk_d      = sclk_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d                 = StSetup;
                    csn_d                   = 1'b0;
                    sclk_d                  = 1'b0;
                    bit_d                   = BW'(NBITS - 1);
                    sr_d                    = '0;
                    sr_d[NBITS-1 -: 8]      = cmd;
                    sr_d[NBITS-9 -: 32]     = req_address;
                    sr_d[31:0]              = req_write ? req_wdata : 32'h0;
                end
            end
            StSetup: begin
                if (rise) state_d = StShift;
            end
            StShift: begin
                if (rise) begin
                    sclk_d = 1'b1;
                    miso_d = miso;
                end else if (fall) begin
                    sclk_d = 1'b0;
                    sr_d   = {sr_q[NBITS-2:0], miso_q};
                    if (bit_q == '0) state_d = StHold;
                    else             bit_d   = bit_q - BW'(1);
                end
            end
            StHold: begin
                if (rise) begin
                    state_d     = StGap;
                    csn_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = sr_q[31:0];
                    gap_d       = GW'(CLK_DIV - 1);
                end
            end
            StGap: begin
                if (gap_q == '0) state_d = StIdle;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            miso_q      <= 1'b0;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            miso_q      <= miso_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign csn       = csn_q;
    assign spi_clk   = sclk_q;
    assign mosi      = ((state_q == StSetup) || (state_q == StShift)) && sr_q[NBITS-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/spi_bridge_master.md
# spi_bridge_master

SPI master that issues single 32-bit register transactions to the on-board SPI-to-Avalon slave, the far end of the link carrying `spi_clk`/`csn`/`mosi`/`miso`. A local request/response port is serialised into one fixed-length SPI frame in mode 0, MSB first. The block is used by the control FPGA/µC-side logic and as the bus-functional master in the slave's system bench.

## Interface

**Parameters**
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period; must be ≥ 1.
- `WAIT_BYTES`, default 1: dummy bytes between address and data, giving the slave time to complete its Avalon access.

**Ports.** One clock; reset is synchronous and active-low.
- `clk` in 1: system clock; everything is on its rising edge.
- `nreset` in 1: synchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_byte_enable` in 4: byte lanes.
- `req_address` in 32: Avalon address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle pulse when the frame has ended.
- `rsp_rdata` out 32: read data; for writes it holds whatever was captured in the data phase.
- `busy` out 1: a frame is in progress.
- `spi_clk` out 1; `csn` out 1; `mosi` out 1; `miso` in 1.

## Operation

**Frame layout:** `NBITS` = 72 + 8·`WAIT_BYTES`, sent MSB first.
- Command byte: bit 7 = write, bits 6:4 = 0, bits 3:0 = byte enable.
- Address: 32 bits.
- Dummy bytes: `WAIT_BYTES` × 8 bits of 0.
- Data: 32 bits. For a write it is `req_wdata`; for a read `mosi` = 0.

**Handshake**
- A request is accepted when `req_valid && req_ready`.
- All request fields are latched into a shift register at acceptance; inputs are don't-care afterwards.
- `req_ready` = 1 only in IDLE.

**Response**
- `miso` is shifted in on every bit of the frame.
- `rsp_rdata` = the last 32 bits captured.
- `rsp_valid` fires for both reads and writes.

**State machine**
- IDLE → SETUP on acceptance.
- SETUP: `csn` = 0, `spi_clk` = 0, for `CLK_DIV` cycles; `mosi` presents bit `NBITS`-1.
- SHIFT: `NBITS` bits, each lasting 2·`CLK_DIV` cycles (low phase, then high phase).
  - Rising `spi_clk` samples `miso`.
  - On falling `spi_clk`, `mosi` moves to the next bit.
  - After the last high phase, `spi_clk` returns to 0.
- HOLD: `csn` = 0, `spi_clk` = 0, for `CLK_DIV` cycles.
- GAP: `csn` = 1 for `CLK_DIV` cycles. `rsp_valid` pulses in the first GAP cycle.
- GAP → IDLE.

**Reset values** (synchronous, on any edge with `nreset` = 0)
- `csn` = 1, `spi_clk` = 0, `mosi` = 0.
- `rsp_valid` = 0, `rsp_rdata` = 0, `busy` = 0, `req_ready` = 1 once released.
- Reset mid-frame aborts immediately: `csn` rises on that edge and no `rsp_valid` is produced.

## Timing

- `csn` falls on the edge after acceptance.
- `busy` = 1 from that edge until the last GAP cycle inclusive.
- Frame duration from acceptance to `rsp_valid`: 1 + `CLK_DIV` + 2·`CLK_DIV`·`NBITS` + `CLK_DIV` cycles. Defaults: 1 + 4 + 640 + 4 = 649.
- Next acceptance is possible `CLK_DIV` + 1 cycles after `rsp_valid`, i.e. after GAP.
- `miso` is sampled in the same `clk` cycle in which the `spi_clk` register is driven 1; no internal synchroniser is applied.
- Half-period counter: counts 0..`CLK_DIV`-1. Bit counter: width $clog2(`NBITS`), counts down, no wrap.
- `req_valid` held during a frame is ignored and is accepted in IDLE.

## Structure

**Package `spi_bridge_pkg`**
- State enum: IDLE, SETUP, SHIFT, HOLD, GAP.
- Command bit positions: `CMD_WRITE_BIT` = 7, `CMD_BE_LSB` = 0.
- Function `frame_bits(WAIT_BYTES)`.

**Sub-module `spi_bridge_tick`**
- Half-period counter producing `rise`/`fall` strobes.
- Enabled only in SETUP, SHIFT and HOLD.

**Top level:** FSM plus a single `NBITS`-wide shift register. Bits are shifted out from the MSB; `miso` is shifted in at the LSB.

## Test plan

- **Write:** `req_write` = 1, BE = 0xF, addr = 0x0000_0010, wdata = 0xDEAD_BEEF, defaults.
  - `mosi` sequence = 0x8F, 0x00000010, 0x00, 0xDEADBEEF.
  - `rsp_valid` 649 cycles after acceptance.
  - 80 `spi_clk` pulses, each high for 4 cycles.
- **Read:** addr = 0x0000_0004, BE = 0x3; slave model drives 0xCAFE_F00D in the data phase.
  - `mosi` command = 0x03.
  - `rsp_rdata` = 0xCAFE_F00D.
- **Back-to-back:** `req_valid` held high for two requests.
  - Second `csn` falling edge occurs exactly 5 cycles after the first `rsp_valid`.
  - `req_ready` = 0 throughout the first frame.
- **Reset mid-frame:** `nreset` = 0 at bit 30 of the address phase.
  - Next edge: `csn` = 1, `spi_clk` = 0, `mosi` = 0.
  - No `rsp_valid`.
  - A following write completes correctly.
- **`CLK_DIV` = 1, `WAIT_BYTES` = 0:**
  - `NBITS` = 72.
  - Frame = 1 + 1 + 144 + 1 = 147 cycles.
  - `spi_clk` toggles every cycle.
- **Request-field change during a frame:** `req_address` changes mid-frame.
  - Transmitted address is unchanged.
  - `busy` deasserts only after GAP.
